ysyx_23060111_lsu: RTL
======================

Name: ysyx_23060111_lsu

Overview:
Load/store unit: the initiator side of the data-memory port. It accepts one load or store from the execute stage over a valid/ready handshake and drives the DPI-backed memory port (m_raddr/m_rmask/m_ren, m_waddr/m_wdata/m_wmask/m_wen). It then aligns, masks and extends the read data and returns the result to writeback over a second valid/ready handshake. Only one transaction is outstanding at a time.

Parameters:
MEM_LAT, 0, extra wait cycles the access is held before read data is sampled or the write is committed (0..15).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  LSU can accept a request
in_wr  in  1  1=store, 0=load
in_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
in_addr  in  32  byte address
in_wdata  in  32  store data, right-aligned
out_valid  out  1  response valid
out_ready  in  1  consumer accepts response
out_rdata  out  32  load result (0 for stores)
out_err  out  1  misaligned or illegal funct3
m_raddr  out  32  word-aligned read address
m_rmask  out  32  byte-lane read mask, bits [3:0]
m_ren  out  1  read enable; memory returns m_rdata combinationally
m_rdata  in  32  full aligned word
m_waddr  out  32  word-aligned write address
m_wdata  out  32  lane-shifted write data
m_wmask  out  32  byte-lane write mask, bits [3:0]
m_wen  out  1  write enable; memory commits at posedge clk

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0, out_rdata=0, out_err=0, m_ren=0, m_wen=0, all address/mask/data outputs 0.
- in_ready=1 only in IDLE and only while rst=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on in_valid && in_ready, register in_wr, in_funct3, in_addr, in_wdata; off=addr[1:0]. If the request is illegal (see Optional Feature), go to RESP with out_err=1 and issue no memory access. Otherwise load cnt=MEM_LAT and go to ACCESS.
- ACCESS: m_raddr/m_waddr = {addr[31:2],2'b00}.
  - Lane mask per access size: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111. Upper 28 mask bits are 0.
  - Load: m_ren=1 every ACCESS cycle, m_rmask = lane mask.
  - Store: m_wdata = in_wdata<<(8*off), m_wmask = lane mask. m_wen=1 only in the final ACCESS cycle (cnt==0), so the write commits exactly once.
  - cnt decrements each cycle. When cnt==0:
    - load: sample m_rdata, form out_rdata = (m_rdata>>(8*off)) sign-extended (LB/LH) or zero-extended (LBU/LHU/LW) to 32 bits.
    - store: out_rdata=0.
    - Then go to RESP.
  - Access latency from request acceptance to out_valid: MEM_LAT+2 cycles.
- RESP: out_valid=1; out_rdata and out_err held stable. On out_ready go to IDLE and drop out_valid. Back-to-back request acceptance next cycle is allowed.
- m_ren and m_wen are 0 outside ACCESS and are gated with !rst. A reset asserted during a store's final ACCESS cycle suppresses the write.
- Reset mid-transaction: next edge returns to IDLE with reset values; the in-flight response is discarded.
- in_valid held high while in_ready=0 is ignored (no queueing).

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined:
  - Misaligned access (half with off[0]=1; word with off!=0) flags out_err=1 with no memory access, out_rdata=0.
  - Unsupported funct3 (load 011/110/111; store 011..111) does the same.
- Undefined:
  - out_err is tied 0.
  - Offset is truncated to natural alignment (half: off&2'b10; word: 2'b00) and the access proceeds.
  - Unsupported funct3 is treated as word size.

Test Plan:
- MEM_LAT=0; memory word at 0x80000000 = 0x8899AABB; LB addr 0x80000001 -> m_raddr=0x80000000, m_rmask=0x2, out_rdata=0xFFFFFFAA at cycle 2, out_err=0.
- Same word; LHU addr 0x80000002 -> m_rmask=0xC, out_rdata=0x00008899; then LW addr 0x80000000 -> out_rdata=0x8899AABB.
- SB wdata=0x12345678 addr 0x80000003 -> single m_wen pulse, m_wdata=0x78000000, m_wmask=0x8; LW readback = 0x7899AABB.
- MEM_LAT=3; SH addr 0x80000004 -> m_wen high exactly one cycle (4th ACCESS cycle), out_valid at cycle 5. Hold out_ready=0 for 4 cycles -> out_valid and in_ready=0 stay stable; release -> IDLE next cycle.
- LSU_ALIGN_CHECK_EN defined; LW addr 0x80000002 -> out_err=1, m_ren never asserted, out_rdata=0, out_valid at cycle 1. Undefined: same request -> m_raddr=0x80000000, m_rmask=0xF, out_err=0.
- MEM_LAT=2; rst asserted in the final ACCESS cycle of an SW -> m_wen=0 that cycle, memory unchanged, out_valid=0, in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one outstanding access, valid/ready in and out, DPI-style memory port.
// Optional LSU_ALIGN_CHECK_EN flags misaligned/unsupported requests instead of truncating them.
module ysyx_23060111_lsu #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wr,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic [31:0] m_raddr,
    output logic [31:0] m_rmask,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_waddr,
    output logic [31:0] m_wdata,
    output logic [31:0] m_wmask,
    output logic        m_wen
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned WADR_W = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    state_t state, state_next;

    logic              wr_q;
    size_t             size_q;
    logic              sext_q;
    logic [1:0]        off_q;
    logic [WADR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    size_t             req_size;
    logic              req_sext;
    logic [1:0]        req_off;
    logic              req_err;
`ifdef LSU_ALIGN_CHECK_EN
    logic              req_legal;
`endif

    logic              last_beat;
    logic [3:0]        lane;
    logic [XLEN-1:0]   rshift;
    logic [XLEN-1:0]   load_data;

    assign last_beat = (cnt_q == '0);

    // Request decode: access size, extension and effective lane offset.
    always_comb begin
        req_size = SZ_W;
        req_sext = 1'b0;
        case (in_funct3)
            3'b000: begin
                req_size = SZ_B;
                req_sext = !in_wr;
            end
            3'b001: begin
                req_size = SZ_H;
                req_sext = !in_wr;
            end
            3'b100: if (!in_wr) req_size = SZ_B;
            3'b101: if (!in_wr) req_size = SZ_H;
            default: req_size = SZ_W;
        endcase

        case (req_size)
            SZ_B:    req_off = in_addr[1:0];
            SZ_H:    req_off = {in_addr[1], 1'b0};
            default: req_off = 2'b00;
        endcase

`ifdef LSU_ALIGN_CHECK_EN
        req_legal = in_wr ? (in_funct3 <= 3'b010)
                          : !((in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11));
        // Misaligned exactly when natural-alignment truncation would move the offset.
        req_err   = !req_legal || (req_off != in_addr[1:0]);
`else
        req_err   = 1'b0;
`endif
    end

    // Byte-lane mask and read-data alignment/extension for the held request.
    always_comb begin
        case (size_q)
            SZ_B:    lane = 4'(4'b0001 << off_q);
            SZ_H:    lane = 4'(4'b0011 << off_q);
            default: lane = 4'b1111;
        endcase

        rshift = m_rdata >> {off_q, 3'b000};

        case (size_q)
            SZ_B:    load_data = {{24{sext_q & rshift[7]}}, rshift[7:0]};
            SZ_H:    load_data = {{16{sext_q & rshift[15]}}, rshift[15:0]};
            default: load_data = rshift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state plus the handshake and memory-port strobes.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        m_ren      = 1'b0;
        m_wen      = 1'b0;
        m_raddr    = '0;
        m_rmask    = '0;
        m_waddr    = '0;
        m_wdata    = '0;
        m_wmask    = '0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_next = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                if (wr_q) begin
                    m_waddr = {addr_q, 2'b00};
                    m_wdata = wdata_q << {off_q, 3'b000};
                    m_wmask = {28'b0, lane};
                    m_wen   = last_beat && !rst;
                end else begin
                    m_raddr = {addr_q, 2'b00};
                    m_rmask = {28'b0, lane};
                    m_ren   = !rst;
                end
                if (last_beat) state_next = RESP;
            end
            RESP: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            size_q    <= SZ_W;
            sext_q    <= 1'b0;
            off_q     <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wr_q      <= in_wr;
                        size_q    <= req_size;
                        sext_q    <= req_sext;
                        off_q     <= req_off;
                        addr_q    <= in_addr[31:2];
                        wdata_q   <= in_wdata;
                        cnt_q     <= CNT_W'(MEM_LAT);
                        out_err   <= req_err;
                        out_rdata <= '0;
                        out_valid <= req_err;
                    end
                end
                ACCESS: begin
                    if (last_beat) begin
                        out_rdata <= wr_q ? '0 : load_data;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
